// File: rtl/brushless_commutator_if.sv
// brushless_commutator_if: hall/brake/drive inputs and coil-select/duty outputs of the commutator
interface brushless_commutator_if;
  logic        hallGrn;
  logic        hallYlw;
  logic        hallBlu;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic        PWM_synch;
  logic [10:0] duty;
  logic [1:0]  selGrn;
  logic [1:0]  selYlw;
  logic [1:0]  selBlu;
  logic        hall_err;
  logic        stall;
  modport master (
    output hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
    input  duty, selGrn, selYlw, selBlu, hall_err, stall
  );
  modport slave (
    input  hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch,
    output duty, selGrn, selYlw, selBlu, hall_err, stall
  );
endinterface

// File: rtl/brushless_commutator.sv
// brushless_commutator: hall decode to coil selects and duty, updated only on PWM period boundaries
module brushless_commutator #(
  parameter logic [10:0] BRAKE_DUTY    = 11'h600,
  parameter int          ERR_PERIODS   = 4,
  parameter int          STALL_PERIODS = 1023
) (
  input logic              clk,
  input logic              rst,
  brushless_commutator_if.slave bus
);
  localparam logic [3:0] ERR_MAX   = 4'(ERR_PERIODS);
  localparam logic [9:0] STALL_MAX = 10'(STALL_PERIODS);
  logic [3:0]  sync1, sync2;
  logic [2:0]  hall_s, rot_state;
  logic        brk, valid, stall_clr;
  logic [5:0]  tbl, sel, sel_nxt;
  logic [10:0] duty, duty_nxt;
  logic [3:0]  err_cnt, err_nxt;
  logic [9:0]  stall_cnt, stall_nxt;
  logic        hall_err, stall;
  // synchronizers idle at "hall 111, brake released"
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {bus.hallGrn, bus.hallYlw, bus.hallBlu, bus.brake_n};
      sync2 <= sync1;
    end
  assign hall_s = sync2[3:1];
  assign brk    = ~sync2[0];
  assign valid  = hall_s != 3'b000 && hall_s != 3'b111;
  always_comb begin
    tbl = 6'b000000;
    case (hall_s)
      3'b101:  tbl = 6'b01_10_00;
      3'b100:  tbl = 6'b01_00_10;
      3'b110:  tbl = 6'b00_01_10;
      3'b010:  tbl = 6'b10_01_00;
      3'b011:  tbl = 6'b10_00_01;
      3'b001:  tbl = 6'b00_10_01;
      default: tbl = 6'b000000;
    endcase
    sel_nxt   = brk ? 6'b11_11_11 : tbl;
    duty_nxt  = brk ? BRAKE_DUTY : 11'h400 + {1'b0, bus.drv_mag[11:2]};
    err_nxt   = valid ? 4'd0 : ((err_cnt == ERR_MAX) ? err_cnt : err_cnt + 4'd1);
    stall_clr = brk || bus.drv_mag == 12'd0 || !valid || hall_s != rot_state;
    stall_nxt = stall_clr ? 10'd0 : ((stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 10'd1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      duty      <= '0;
      sel       <= '0;
      err_cnt   <= '0;
      stall_cnt <= '0;
      rot_state <= '0;
      hall_err  <= 1'b0;
      stall     <= 1'b0;
    end else if (bus.PWM_synch) begin
      duty      <= duty_nxt;
      sel       <= sel_nxt;
      err_cnt   <= err_nxt;
      stall_cnt <= stall_nxt;
      rot_state <= hall_s;
      hall_err  <= err_nxt == ERR_MAX;
      stall     <= stall_nxt == STALL_MAX;
    end
  assign bus.duty     = duty;
  assign bus.selGrn   = sel[5:4];
  assign bus.selYlw   = sel[3:2];
  assign bus.selBlu   = sel[1:0];
  assign bus.hall_err = hall_err;
  assign bus.stall    = stall;
endmodule

// File: tb/tb_brushless_commutator.sv
// tb_brushless_commutator: randomized and directed checks against a period-level reference model
module tb_brushless_commutator;
  localparam int EP = 4;
  localparam int SP = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  brushless_commutator_if bus();
  brushless_commutator #(.BRAKE_DUTY(11'h600), .ERR_PERIODS(EP), .STALL_PERIODS(SP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  logic [5:0]  tbl [8];
  logic [2:0]  m_hall, m_prev;
  logic        m_brk;
  logic [11:0] m_mag;
  int          err_run, stall_run;
  logic [18:0] exp_v;
  wire  [18:0] obs = {bus.duty, bus.selGrn, bus.selYlw, bus.selBlu, bus.hall_err, bus.stall};
  task automatic set_in(input logic [2:0] h, input logic b, input logic [11:0] m);
    {bus.hallGrn, bus.hallYlw, bus.hallBlu} = h;
    bus.brake_n = ~b;
    bus.drv_mag = m;
    m_hall = h;
    m_brk  = b;
    m_mag  = m;
  endtask
  task automatic model_reset();
    err_run   = 0;
    stall_run = 0;
    m_prev    = 3'b000;
    exp_v     = '0;
  endtask
  // one PWM period as seen by the controller: runs of invalid codes and of unchanged rotation
  task automatic model_step();
    logic        ok;
    logic [10:0] d;
    ok = m_hall != 3'd0 && m_hall != 3'd7;
    err_run   = ok ? 0 : err_run + 1;
    stall_run = (m_brk || m_mag == 0 || !ok || m_hall != m_prev) ? 0 : stall_run + 1;
    m_prev    = m_hall;
    d = 11'(int'(m_mag) / 4 + 'h400);
    exp_v = {m_brk ? 11'h600 : d, m_brk ? 6'h3f : tbl[m_hall], err_run >= EP, stall_run >= SP};
  endtask
  task automatic pulse(input int n);
    repeat (n) @(posedge clk);
    #1 bus.PWM_synch = 1'b1;
    @(posedge clk);
    #1 bus.PWM_synch = 1'b0;
    model_step();
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 19'd0) begin
      n_fail++;
      $display("FAIL reset obs=%h exp=%h", obs, 19'd0);
    end
    rst = 1'b0;
  endtask
  task automatic test_first_vector();
    set_in(3'b101, 1'b0, 12'h800);
    pulse(3);
    n_checks++;
    if ({bus.duty, bus.selGrn, bus.selYlw, bus.selBlu} !== {11'h600, 6'b01_10_00}) begin
      n_fail++;
      $display("FAIL first_vector duty=%h sel=%b%b%b exp duty=600 sel=011000", bus.duty, bus.selGrn, bus.selYlw, bus.selBlu);
    end
  endtask
  task automatic test_table_walk();
    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    for (int i = 0; i < 6; i++) begin
      set_in(seq[i], 1'b0, 12'($urandom_range(1, 4095)));
      pulse(3);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL table h=%b obs=%h exp=%h", seq[i], obs, exp_v);
      end
      repeat (3) @(posedge clk);
      #1 {bus.hallGrn, bus.hallYlw, bus.hallBlu} = ~seq[i];
      bus.drv_mag = 12'($urandom);
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hold h=%b obs=%h exp=%h", seq[i], obs, exp_v);
      end
    end
  endtask
  task automatic test_brake();
    set_in(3'b011, 1'b1, 12'hFFF);
    pulse(2);
    n_checks++;
    if (obs !== exp_v || {bus.duty, bus.selGrn, bus.selYlw, bus.selBlu} !== {11'h600, 6'h3f}) begin
      n_fail++;
      $display("FAIL brake obs=%h exp=%h", obs, exp_v);
    end
    set_in(3'b011, 1'b0, 12'hFFF);
    pulse(3);
    n_checks++;
    if (obs !== exp_v || {bus.duty, bus.selGrn, bus.selYlw, bus.selBlu} !== {11'h7FF, 6'b10_00_01}) begin
      n_fail++;
      $display("FAIL brake_release obs=%h exp=%h", obs, exp_v);
    end
  endtask
  task automatic test_hall_err();
    set_in(3'b111, 1'b0, 12'h123);
    for (int i = 0; i < 4; i++) begin
      pulse(3);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hall_err_run p=%0d obs=%h exp=%h", i + 1, obs, exp_v);
      end
    end
    n_checks++;
    if (bus.hall_err !== 1'b1) begin
      n_fail++;
      $display("FAIL hall_err_set obs=%b exp=1", bus.hall_err);
    end
    set_in(3'b001, 1'b0, 12'h123);
    pulse(3);
    n_checks++;
    if (bus.hall_err !== 1'b0 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL hall_err_clear obs=%h exp=%h", obs, exp_v);
    end
  endtask
  task automatic test_back_to_back();
    set_in(3'b000, 1'b0, 12'h050);
    repeat (3) @(posedge clk);
    #1 bus.PWM_synch = 1'b1;
    repeat (EP) @(posedge clk);
    #1 bus.PWM_synch = 1'b0;
    repeat (EP) model_step();
    n_checks++;
    if (obs !== exp_v || bus.hall_err !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back obs=%h exp=%h", obs, exp_v);
    end
  endtask
  task automatic test_stall();
    set_in(3'b110, 1'b0, 12'h100);
    for (int i = 0; i < SP + 2; i++) begin
      pulse(3);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stall_run p=%0d obs=%h exp=%h", i + 1, obs, exp_v);
      end
    end
    n_checks++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_set obs=%b exp=1", bus.stall);
    end
    set_in(3'b110, 1'b0, 12'h000);
    pulse(3);
    n_checks++;
    if (bus.stall !== 1'b0 || obs !== exp_v) begin
      n_fail++;
      $display("FAIL stall_clear obs=%h exp=%h", obs, exp_v);
    end
    set_in(3'b110, 1'b0, 12'h100);
    for (int i = 0; i < SP + 2; i++) pulse(3);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL stall_rerun obs=%h exp=%h", obs, exp_v);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_midrun obs=%h exp=%h", obs, 19'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulse(3);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL after_reset obs=%h exp=%h", obs, exp_v);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      set_in(3'($urandom), $urandom_range(0, 5) == 0,
             ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom));
      if ($urandom_range(0, 3) == 0) set_in(m_hall, m_brk, m_mag);
      pulse($urandom_range(2, 5));
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random i=%0d h=%b brk=%b mag=%h obs=%h exp=%h", i, m_hall, m_brk, m_mag, obs, exp_v);
      end
    end
    set_in(3'b010, 1'b0, 12'h444);
    for (int i = 0; i < SP + 1; i++) pulse(3);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL random_stall obs=%h exp=%h", obs, exp_v);
    end
  endtask
  initial begin
    tbl = '{6'b000000, 6'b00_10_01, 6'b10_01_00, 6'b10_00_01,
            6'b01_00_10, 6'b01_10_00, 6'b00_01_10, 6'b000000};
    bus.PWM_synch = 1'b0;
    set_in(3'b111, 1'b0, 12'h000);
    model_reset();
    test_reset();
    test_first_vector();
    test_table_walk();
    test_brake();
    test_hall_err();
    test_back_to_back();
    test_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
